// File: rtl/tug_match_referee_pkg.sv
// Shared types and constants for the tug-of-war match referee.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        PAUSE      = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2
    } winner_t;

    // Active-low segments, bit 6 first; all off.
    localparam logic [6:0] HEX_OFF = 7'b1111111;

    // Digit patterns 0..9, index 0 listed first.
    localparam logic [0:9][6:0] DIGIT_SEG = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/tug_match_referee_seg7_digit.sv
// Single decimal digit to active-low 7-segment decoder; blank outside 0..9.
module seg7_digit
    import tug_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    // Table lookup for legal digits, blank otherwise.
    always_comb begin
        seg = HEX_OFF;
        if (value <= 4'd9) begin
            seg = DIGIT_SEG[value];
        end
    end

endmodule

// File: rtl/tug_match_referee.sv
// Best-of match referee: counts round wins, pauses the field between rounds
// and latches the match winner once a player reaches WIN_ROUNDS.
module tug_match_referee
    import tug_pkg::*;
#(
    parameter int WIN_ROUNDS   = 3,
    parameter int PAUSE_CYCLES = 4,
    parameter int SCORE_W      = $clog2(WIN_ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L,
    input  logic               R,
    input  logic               leftOn,
    input  logic               rightOn,
    output logic               roundReset,
    output logic               matchOver,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [6:0]         hexScore1,
    output logic [6:0]         hexScore2,
    output logic [6:0]         playerWin
);

    localparam int PC_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PC_W-1:0]    PC_INIT    = PC_W'(PAUSE_CYCLES - 1);
    // A point scored from this count is the match-winning one.
    localparam logic [SCORE_W-1:0] LAST_SCORE = SCORE_W'(WIN_ROUNDS - 1);

    state_t          state;
    winner_t         winner;
    logic [PC_W-1:0] pause_cnt;
    logic            p1_point;
    logic            p2_point;
    logic [3:0]      digit1;
    logic [3:0]      digit2;

    assign p1_point = rightOn & R;
    assign p2_point = leftOn & L;

    // Round/match state machine; P1 has priority on a simultaneous point.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            winner    <= NONE;
            pause_cnt <= '0;
            score1    <= '0;
            score2    <= '0;
        end else begin
            case (state)
                PLAY: begin
                    if (p1_point) begin
                        score1 <= score1 + 1'b1;
                        if (score1 == LAST_SCORE) begin
                            state  <= MATCH_OVER;
                            winner <= P1;
                        end else begin
                            state     <= PAUSE;
                            pause_cnt <= PC_INIT;
                        end
                    end else if (p2_point) begin
                        score2 <= score2 + 1'b1;
                        if (score2 == LAST_SCORE) begin
                            state  <= MATCH_OVER;
                            winner <= P2;
                        end else begin
                            state     <= PAUSE;
                            pause_cnt <= PC_INIT;
                        end
                    end
                end
                PAUSE: begin
                    if (pause_cnt == '0) begin
                        state <= PLAY;
                    end else begin
                        pause_cnt <= pause_cnt - 1'b1;
                    end
                end
                MATCH_OVER: begin
                    state <= MATCH_OVER;
                end
                default: begin
                    state <= PLAY;
                end
            endcase
        end
    end

    assign roundReset = (state != PLAY);
    assign matchOver  = (state == MATCH_OVER);

    // Zero-extend the score counters to the decoder's digit width.
    always_comb begin
        digit1 = '0;
        digit2 = '0;
        digit1[SCORE_W-1:0] = score1;
        digit2[SCORE_W-1:0] = score2;
    end

    seg7_digit u_hex1 (
        .value (digit1),
        .seg   (hexScore1)
    );

    seg7_digit u_hex2 (
        .value (digit2),
        .seg   (hexScore2)
    );

    // Winner banner: blank until decided, then "1" or "2".
    always_comb begin
        case (winner)
            P1:      playerWin = 7'b1111001;
            P2:      playerWin = 7'b0100100;
            default: playerWin = HEX_OFF;
        endcase
    end

endmodule

// File: tb/tb_tug_match_referee.sv
// Self-checking bench for tug_match_referee: a score/pause model compared every
// cycle, plus literal spot checks and a WIN_ROUNDS=1 instance.
module tb_tug_match_referee;

    localparam int WR = 3;
    localparam int PC = 2;

    logic clk = 1'b0;
    logic reset, L, R, leftOn, rightOn;
    logic roundReset, matchOver;
    logic [1:0] score1, score2;
    logic [6:0] hexScore1, hexScore2, playerWin;

    // Second instance, single-round match.
    logic b_R, b_rightOn;
    logic b_roundReset, b_matchOver;
    logic b_score1, b_score2;
    logic [6:0] b_hex1, b_hex2, b_win;

    int checks = 0;
    int passed = 0;
    bit check_en = 1'b0;

    // Model state: round counts, remaining held cycles, match decided, winner.
    int m_s1, m_s2, m_hold, m_over, m_win;

    always #5 clk = ~clk;

    tug_match_referee #(.WIN_ROUNDS(WR), .PAUSE_CYCLES(PC)) dut (
        .clk(clk), .reset(reset), .L(L), .R(R), .leftOn(leftOn), .rightOn(rightOn),
        .roundReset(roundReset), .matchOver(matchOver),
        .score1(score1), .score2(score2),
        .hexScore1(hexScore1), .hexScore2(hexScore2), .playerWin(playerWin)
    );

    tug_match_referee #(.WIN_ROUNDS(1), .PAUSE_CYCLES(PC)) dut_one (
        .clk(clk), .reset(reset), .L(1'b0), .R(b_R), .leftOn(1'b0), .rightOn(b_rightOn),
        .roundReset(b_roundReset), .matchOver(b_matchOver),
        .score1(b_score1), .score2(b_score2),
        .hexScore1(b_hex1), .hexScore2(b_hex2), .playerWin(b_win)
    );

    function automatic int seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int banner_of(input int w);
        case (w)
            1: return 7'b1111001;
            2: return 7'b0100100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Game rules: a held field ignores input; a point either ends the match or
    // holds the field for PC cycles. Right-side point wins ties.
    always @(posedge clk) begin
        if (reset) begin
            m_s1 <= 0; m_s2 <= 0; m_hold <= 0; m_over <= 0; m_win <= 0;
        end else if (m_over != 0) begin
            m_over <= 1;
        end else if (m_hold > 0) begin
            m_hold <= m_hold - 1;
        end else if (rightOn && R) begin
            m_s1 <= m_s1 + 1;
            if (m_s1 + 1 == WR) begin m_over <= 1; m_win <= 1; end
            else m_hold <= PC;
        end else if (leftOn && L) begin
            m_s2 <= m_s2 + 1;
            if (m_s2 + 1 == WR) begin m_over <= 1; m_win <= 2; end
            else m_hold <= PC;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("score1", int'(score1), m_s1);
            chk("score2", int'(score2), m_s2);
            chk("hexScore1", int'(hexScore1), seg_of(m_s1));
            chk("hexScore2", int'(hexScore2), seg_of(m_s2));
            chk("roundReset", int'(roundReset), (m_hold > 0 || m_over != 0) ? 1 : 0);
            chk("matchOver", int'(matchOver), m_over);
            chk("playerWin", int'(playerWin), banner_of(m_win));
        end
    end

    task automatic drive(input logic rst, input logic l, input logic r,
                         input logic lo, input logic ro);
        @(negedge clk);
        reset = rst; L = l; R = r; leftOn = lo; rightOn = ro;
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; L = 1'b0; R = 1'b0; leftOn = 1'b0; rightOn = 1'b0;
        b_R = 1'b0; b_rightOn = 1'b0;
        after_edge();
        check_en = 1'b1;
        drive(1, 0, 0, 0, 0);

        // Idle with R held but rightOn low: no point.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        after_edge();
        chk("idle score1", int'(score1), 0);
        chk("idle score2", int'(score2), 0);
        chk("idle roundReset", int'(roundReset), 0);
        chk("idle hexScore1", int'(hexScore1), 7'b1000000);
        chk("idle playerWin", int'(playerWin), 7'b1111111);

        // Single-round instance: first point ends the match with no pause.
        @(negedge clk); b_R = 1'b1; b_rightOn = 1'b1;
        after_edge();
        chk("one score1", int'(b_score1), 1);
        chk("one matchOver", int'(b_matchOver), 1);
        chk("one roundReset", int'(b_roundReset), 1);
        chk("one playerWin", int'(b_win), 7'b1111001);
        @(negedge clk); b_R = 1'b0;
        after_edge();
        chk("one frozen score1", int'(b_score1), 1);
        chk("one hexScore1", int'(b_hex1), 7'b1111001);

        // P1 point, then a second point attempt inside the pause.
        drive(0, 0, 1, 0, 1);
        after_edge();
        chk("p1 score1", int'(score1), 1);
        chk("p1 hexScore1", int'(hexScore1), 7'b1111001);
        chk("pause rr1", int'(roundReset), 1);
        drive(0, 0, 1, 0, 1);
        after_edge();
        chk("pause ignored score1", int'(score1), 1);
        chk("pause rr2", int'(roundReset), 1);
        drive(0, 0, 0, 0, 1);
        after_edge();
        chk("pause released", int'(roundReset), 0);

        // Simultaneous points: right side wins.
        drive(0, 1, 1, 1, 1);
        after_edge();
        chk("tie score1", int'(score1), 2);
        chk("tie score2", int'(score2), 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        // P2 takes three rounds.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0);
            drive(0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
        end
        after_edge();
        chk("match score2", int'(score2), 3);
        chk("match hexScore2", int'(hexScore2), 7'b0110000);
        chk("match matchOver", int'(matchOver), 1);
        chk("match roundReset", int'(roundReset), 1);
        chk("match playerWin", int'(playerWin), 7'b0100100);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 1);
        after_edge();
        chk("frozen score1", int'(score1), 2);
        chk("frozen score2", int'(score2), 3);
        chk("frozen playerWin", int'(playerWin), 7'b0100100);

        // Reset during a pause.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0);
        after_edge();
        chk("pre-reset rr", int'(roundReset), 1);
        drive(1, 1, 1, 1, 1);
        after_edge();
        chk("reset rr", int'(roundReset), 0);
        chk("reset score1", int'(score1), 0);
        chk("reset matchOver", int'(matchOver), 0);
        drive(0, 1, 0, 1, 0);
        after_edge();
        chk("post-reset score2", int'(score2), 1);
        chk("post-reset hexScore2", int'(hexScore2), 7'b1111001);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
